// File: rtl/pkg_mem_arb.sv
// Shared state type and requester constants for the spcpu memory arbiter.
package pkg_mem_arb;
    localparam int MEM_ARB_NUM_REQ = 2;
    localparam int MEM_ARB_REQ_CPU = 0;
    localparam int MEM_ARB_REQ_DMA = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_arb_state_t;
endpackage

// File: rtl/spcpu_mem_arbiter_if.sv
// Requester and memory-side bus of the spcpu memory arbiter.
interface spcpu_mem_arbiter_if;
    import pkg_mem_arb::*;

    logic [MEM_ARB_NUM_REQ-1:0] req;
    logic [15:0]                r0_addr, r1_addr;
    logic [15:0]                r0_wdata, r1_wdata;
    logic                       r0_acc_sz, r1_acc_sz;
    logic                       r0_we, r1_we;
    logic [MEM_ARB_NUM_REQ-1:0] gnt;
    logic [MEM_ARB_NUM_REQ-1:0] done;
    logic [15:0]                rdata;
    logic [15:0]                mem_addr, mem_wdata;
    logic                       mem_acc_sz, mem_we;
    logic [15:0]                mem_rdata;

    modport slave (
        input  req, r0_addr, r1_addr, r0_wdata, r1_wdata,
               r0_acc_sz, r1_acc_sz, r0_we, r1_we, mem_rdata,
        output gnt, done, rdata, mem_addr, mem_wdata, mem_acc_sz, mem_we
    );

    modport master (
        output req, r0_addr, r1_addr, r0_wdata, r1_wdata,
               r0_acc_sz, r1_acc_sz, r0_we, r1_we, mem_rdata,
        input  gnt, done, rdata, mem_addr, mem_wdata, mem_acc_sz, mem_we
    );
endinterface

// File: rtl/spcpu_mem_arb_picker.sv
// Combinational winner selection; SPCPU_MEM_ARB_ROUND_ROBIN_EN picks round-robin,
// otherwise the CPU always wins.
module spcpu_mem_arb_picker
    import pkg_mem_arb::*;
(
    input  logic [MEM_ARB_NUM_REQ-1:0] req,
    input  logic                       last_winner,
    output logic [MEM_ARB_NUM_REQ-1:0] winner
);
`ifdef SPCPU_MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = '0;
        if (req[MEM_ARB_REQ_CPU] && req[MEM_ARB_REQ_DMA])
            winner = last_winner ? 2'b01 : 2'b10;
        else if (req[MEM_ARB_REQ_CPU])
            winner[MEM_ARB_REQ_CPU] = 1'b1;
        else if (req[MEM_ARB_REQ_DMA])
            winner[MEM_ARB_REQ_DMA] = 1'b1;
    end
`else
    logic unused_last_winner;
    assign unused_last_winner = last_winner;

    always_comb begin
        winner = '0;
        if (req[MEM_ARB_REQ_CPU])
            winner[MEM_ARB_REQ_CPU] = 1'b1;
        else if (req[MEM_ARB_REQ_DMA])
            winner[MEM_ARB_REQ_DMA] = 1'b1;
    end
`endif
endmodule

// File: rtl/spcpu_mem_arbiter.sv
// Two-requester memory arbiter holding the memory bus for MEM_LATENCY wait cycles per access.
// Build option SPCPU_MEM_ARB_ROUND_ROBIN_EN adds a last-winner flop for round-robin contention.
//   state   | meaning
//   ST_IDLE | no transaction; grant on any request
//   ST_WAIT | memory access in progress, wait counter running down
//   ST_DONE | access complete; done pulses and gnt drops on the next edge
module spcpu_mem_arbiter
    import pkg_mem_arb::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    spcpu_mem_arbiter_if.slave bus
);
    mem_arb_state_t             state_q, state_d;
    logic [2:0]                 cnt_q;
    logic [MEM_ARB_NUM_REQ-1:0] gnt_q, done_q, winner;
    logic [15:0]                rdata_q, addr_q, wdata_q;
    logic                       acc_sz_q, we_q, last_winner;
    logic                       grant_load, wait_last, txn_end, mem_we_c;

    spcpu_mem_arb_picker u_picker (
        .req         (bus.req),
        .last_winner (last_winner),
        .winner      (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|bus.req) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 3'd1) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_load = (state_q == ST_IDLE) && (|bus.req);
        wait_last  = (state_q == ST_WAIT) && (cnt_q == 3'd1);
        txn_end    = (state_q == ST_DONE);
        mem_we_c   = (state_q == ST_WAIT) && we_q;
    end

    // Requester inputs are captured only on the grant edge; the bus then runs from these copies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            acc_sz_q <= 1'b1;
            we_q     <= 1'b0;
        end else begin
            done_q <= '0;
            if (grant_load) begin
                gnt_q <= winner;
                cnt_q <= 3'(MEM_LATENCY);
                if (winner[MEM_ARB_REQ_DMA]) begin
                    addr_q   <= bus.r1_addr;
                    wdata_q  <= bus.r1_wdata;
                    acc_sz_q <= bus.r1_acc_sz;
                    we_q     <= bus.r1_we;
                end else begin
                    addr_q   <= bus.r0_addr;
                    wdata_q  <= bus.r0_wdata;
                    acc_sz_q <= bus.r0_acc_sz;
                    we_q     <= bus.r0_we;
                end
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (wait_last && !we_q) rdata_q <= bus.mem_rdata;
            if (txn_end) begin
                done_q <= gnt_q;
                gnt_q  <= '0;
            end
        end
    end

`ifdef SPCPU_MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          last_winner <= 1'(MEM_ARB_REQ_DMA);
        else if (grant_load) last_winner <= winner[MEM_ARB_REQ_DMA];
    end
`else
    assign last_winner = 1'(MEM_ARB_REQ_DMA);
`endif

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_acc_sz = acc_sz_q;
    assign bus.mem_we     = mem_we_c;
endmodule

// File: tb/tb_spcpu_mem_arbiter.sv
// Scoreboard bench for spcpu_mem_arbiter at MEM_LATENCY 1 and 4; memory returns addr + 16'h9234.
module tb_spcpu_mem_arbiter;
    import pkg_mem_arb::*;

    typedef struct packed {
        logic [1:0]  who;
        logic [15:0] rdata;
    } exp_t;

`ifdef SPCPU_MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spcpu_mem_arbiter_if a1 ();
    spcpu_mem_arbiter_if a4 ();

    spcpu_mem_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(a1));
    spcpu_mem_arbiter #(.MEM_LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(a4));

    assign a1.mem_rdata = a1.mem_addr + 16'h9234;
    assign a4.mem_rdata = a4.mem_addr + 16'h9234;

    int          n_tests;
    int          n_fail;
    exp_t        sb_q[$];
    logic [15:0] model_rdata;
    logic        model_last;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void push_exp(input logic [1:0] who, input logic we, input logic [15:0] addr);
        if (!we) model_rdata = addr + 16'h9234;
        sb_q.push_back(exp_t'{who: who, rdata: model_rdata});
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset === 1'b1 && a1.done != 2'b00) begin
            if (sb_q.size() == 0) begin
                check_val("sb_spurious_done", 32'(a1.done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_done", 32'(a1.done), 32'(e.who));
                check_val("sb_rdata", 32'(a1.rdata), 32'(e.rdata));
            end
        end
    end

    // One transaction on dut1; requester inputs are scrambled right after the grant.
    task automatic run_txn(input int who, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic sz, input logic we);
        logic [1:0] oh;
        int         n;
        int         we_cyc;
        oh = (who == 1) ? 2'b10 : 2'b01;
        if (who == 1) begin
            a1.r1_addr = addr; a1.r1_wdata = wdata; a1.r1_acc_sz = sz; a1.r1_we = we;
        end else begin
            a1.r0_addr = addr; a1.r0_wdata = wdata; a1.r0_acc_sz = sz; a1.r0_we = we;
        end
        a1.req = oh;
        push_exp(oh, we, addr);
        model_last = (who == 1);
        we_cyc = 0;
        tick();
        n = 1;
        check_val("gnt", 32'(a1.gnt), 32'(oh));
        if (who == 1) begin
            a1.r1_addr = ~addr; a1.r1_wdata = ~wdata; a1.r1_acc_sz = ~sz; a1.r1_we = ~we;
        end else begin
            a1.r0_addr = ~addr; a1.r0_wdata = ~wdata; a1.r0_acc_sz = ~sz; a1.r0_we = ~we;
        end
        while (a1.done == 2'b00 && n < 20) begin
            check_val("hold_addr", 32'(a1.mem_addr), 32'(addr));
            check_val("hold_acc_sz", 32'(a1.mem_acc_sz), 32'(sz));
            if (a1.mem_we) begin
                we_cyc++;
                check_val("we_wdata", 32'(a1.mem_wdata), 32'(wdata));
            end
            tick();
            n++;
        end
        check_val("latency", n, 3);
        check_val("we_cycles", we_cyc, we ? 1 : 0);
        check_val("gnt_drop", 32'(a1.gnt), 32'd0);
        a1.req = 2'b00;
    endtask

    task automatic run_lat4(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        int we_cyc;
        a4.r0_addr = addr; a4.r0_wdata = wdata; a4.r0_acc_sz = 1'b1; a4.r0_we = we;
        a4.req = 2'b01;
        n = 0;
        we_cyc = 0;
        while (a4.done == 2'b00 && n < 20) begin
            tick();
            n++;
            if (a4.mem_we) we_cyc++;
        end
        check_val("lat4_latency", n, 6);
        check_val("lat4_we_cycles", we_cyc, we ? 4 : 0);
        check_val("lat4_done", 32'(a4.done), 32'h1);
        if (!we) check_val("lat4_rdata", 32'(a4.rdata), 32'(addr + 16'h9234));
        a4.req = 2'b00;
    endtask

    int          tv_who[5]   = '{0, 1, 1, 0, 0};
    logic [15:0] tv_addr[5]  = '{16'h8000, 16'h0010, 16'h7FFE, 16'h00FF, 16'h0001};
    logic [15:0] tv_wdata[5] = '{16'h0000, 16'hBEEF, 16'h0000, 16'h00AB, 16'h0000};
    logic        tv_sz[5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tv_we[5]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [1:0] eg[4];
        logic [1:0] prev;
        int         g;
        int         k;
        int         n;
        n_tests = 0;
        n_fail = 0;
        model_rdata = '0;
        model_last = 1'b1;
        a1.req = '0; a1.r0_addr = '0; a1.r1_addr = '0; a1.r0_wdata = '0; a1.r1_wdata = '0;
        a1.r0_acc_sz = 1'b0; a1.r1_acc_sz = 1'b0; a1.r0_we = 1'b0; a1.r1_we = 1'b0;
        a4.req = '0; a4.r0_addr = '0; a4.r1_addr = '0; a4.r0_wdata = '0; a4.r1_wdata = '0;
        a4.r0_acc_sz = 1'b0; a4.r1_acc_sz = 1'b0; a4.r0_we = 1'b0; a4.r1_we = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();
        check_val("rst_gnt", 32'(a1.gnt), 32'd0);
        check_val("rst_done", 32'(a1.done), 32'd0);
        check_val("rst_rdata", 32'(a1.rdata), 32'd0);
        check_val("rst_mem_addr", 32'(a1.mem_addr), 32'd0);
        check_val("rst_mem_wdata", 32'(a1.mem_wdata), 32'd0);
        check_val("rst_mem_acc_sz", 32'(a1.mem_acc_sz), 32'd1);
        check_val("rst_mem_we", 32'(a1.mem_we), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn(tv_who[i], tv_addr[i], tv_wdata[i], tv_sz[i], tv_we[i]);
            tick();
        end

        // Contention: both requesters reading continuously for four completions.
        a1.r0_addr = 16'h1000; a1.r0_we = 1'b0; a1.r0_acc_sz = 1'b1;
        a1.r1_addr = 16'h2000; a1.r1_we = 1'b0; a1.r1_acc_sz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eg[i] = RR_MODE ? (model_last ? 2'b01 : 2'b10) : 2'b01;
            model_last = (eg[i] == 2'b10);
            push_exp(eg[i], 1'b0, (eg[i] == 2'b10) ? 16'h2000 : 16'h1000);
        end
        a1.req = 2'b11;
        prev = 2'b00; g = 0; k = 0; n = 0;
        while (k < 4 && n < 80) begin
            tick();
            n++;
            if (a1.gnt != 2'b00 && prev == 2'b00) begin
                if (g < 4) check_val("cont_gnt", 32'(a1.gnt), 32'(eg[g]));
                else       check_val("cont_extra_gnt", 32'(a1.gnt), 32'd0);
                g++;
            end
            prev = a1.gnt;
            if (a1.done != 2'b00) k++;
        end
        a1.req = 2'b00;
        check_val("cont_done_cnt", k, 4);
        check_val("cont_gnt_cnt", g, 4);
        tick();

        // Reset during the wait cycle of a write.
        a1.r0_addr = 16'h3000; a1.r0_wdata = 16'h5555; a1.r0_we = 1'b1; a1.r0_acc_sz = 1'b1;
        a1.req = 2'b01;
        tick();
        check_val("rst_mid_pre_we", 32'(a1.mem_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_val("rst_mid_we", 32'(a1.mem_we), 32'd0);
        check_val("rst_mid_gnt", 32'(a1.gnt), 32'd0);
        check_val("rst_mid_addr", 32'(a1.mem_addr), 32'd0);
        a1.req = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        model_last = 1'b1;
        model_rdata = '0;
        tick();
        check_val("rst_mid_done", 32'(a1.done), 32'd0);
        check_val("rst_mid_rdata", 32'(a1.rdata), 32'd0);
        run_txn(0, 16'h4444, 16'h0000, 1'b1, 1'b0);
        tick();

        run_lat4(1'b1, 16'h0200, 16'hCAFE);
        tick();
        run_lat4(1'b0, 16'h4000, 16'h0000);
        tick();
        tick();

        check_val("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
